// File: rtl/nano_pkg.sv
// Shared opcode values, FSM state encoding and default widths for the nano sequencer.
// Optional build macro NANO_SEQ_JNZ_EN only changes decode; these constants are identical in both builds.
package nano_pkg;

  localparam int ADDR_W_DEF = 4;
  localparam int OP_W_DEF   = 4;

  localparam int OP_NOP  = 0;
  localparam int OP_JMP  = 1;
  localparam int OP_JZ   = 2;
  localparam int OP_JNZ  = 3;
  // HALT is the all-ones opcode at whatever OP_W is in use; this is the OP_W_DEF value.
  localparam int OP_HALT = (1 << OP_W_DEF) - 1;

  typedef enum logic [1:0] {
    ST_FETCH  = 2'd0,
    ST_DECODE = 2'd1,
    ST_EXEC   = 2'd2,
    ST_HALTED = 2'd3
  } state_t;

endpackage

// File: rtl/nano_branch_resolve.sv
// Combinational decode of the held instruction into PC strobes and the next FSM state.
// With NANO_SEQ_JNZ_EN defined, opcode 3 is JNZ; otherwise it falls into the ALU class.
module nano_branch_resolve
  import nano_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int OP_W   = OP_W_DEF
) (
  input  logic [OP_W-1:0]   op,
  input  logic [ADDR_W-1:0] operand,
  input  logic              zero_flag,
  output logic              count_enable,
  output logic              sload,
  output logic [ADDR_W-1:0] load_data,
  output state_t            next_state
);

  logic take;

  always_comb begin
    take         = 1'b0;
    count_enable = 1'b0;
    next_state   = ST_FETCH;
    if (op == {OP_W{1'b1}}) begin
      next_state = ST_HALTED;
    end else if (op == OP_W'(OP_NOP)) begin
      count_enable = 1'b1;
    end else if (op == OP_W'(OP_JMP)) begin
      take = 1'b1;
    end else if (op == OP_W'(OP_JZ)) begin
      take         = zero_flag;
      count_enable = ~zero_flag;
`ifdef NANO_SEQ_JNZ_EN
    end else if (op == OP_W'(OP_JNZ)) begin
      take         = ~zero_flag;
      count_enable = zero_flag;
`endif
    end else begin
      next_state = ST_EXEC;
    end
    sload     = take;
    load_data = take ? operand : '0;
  end

endmodule

// File: rtl/nano_sequencer.sv
// Fetch/decode/execute control FSM driving the program counter's load/count strobes.
// Build option NANO_SEQ_JNZ_EN (see nano_branch_resolve) enables the JNZ opcode.
module nano_sequencer
  import nano_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int OP_W   = OP_W_DEF
) (
  input  logic                   clock,
  input  logic                   areset,
  input  logic                   run,
  input  logic [ADDR_W-1:0]      pc_value,
  output logic                   pc_count_enable,
  output logic                   pc_sload,
  output logic [ADDR_W-1:0]      pc_load_data,
  output logic [ADDR_W-1:0]      mem_addr,
  output logic                   mem_req,
  input  logic                   mem_ack,
  input  logic [OP_W+ADDR_W-1:0] mem_rdata,
  input  logic                   zero_flag,
  output logic                   exec_valid,
  output logic [OP_W-1:0]        exec_op,
  output logic [ADDR_W-1:0]      exec_operand,
  input  logic                   exec_ready,
  output logic                   halted
);

  localparam int IW = OP_W + ADDR_W;

  state_t            state;
  logic [IW-1:0]     ir;
  logic              br_count_enable;
  logic              br_sload;
  logic [ADDR_W-1:0] br_load_data;
  state_t            br_next;

  nano_branch_resolve #(
    .ADDR_W(ADDR_W),
    .OP_W  (OP_W)
  ) u_branch (
    .op          (ir[IW-1:ADDR_W]),
    .operand     (ir[ADDR_W-1:0]),
    .zero_flag   (zero_flag),
    .count_enable(br_count_enable),
    .sload       (br_sload),
    .load_data   (br_load_data),
    .next_state  (br_next)
  );

  always_ff @(posedge clock or negedge areset) begin
    if (!areset) begin
      state <= ST_FETCH;
      ir    <= '0;
    end else begin
      case (state)
        ST_FETCH: begin
          if (mem_req && mem_ack) begin
            ir    <= mem_rdata;
            state <= ST_DECODE;
          end
        end
        ST_DECODE: state <= br_next;
        ST_EXEC:   if (exec_ready) state <= ST_FETCH;
        default:   state <= ST_HALTED;
      endcase
    end
  end

  // Strobes decode straight from state so a reset assertion clears them without waiting for a clock.
  assign mem_addr        = pc_value;
  assign mem_req         = areset && run && (state == ST_FETCH);
  assign exec_valid      = (state == ST_EXEC);
  assign exec_op         = ir[IW-1:ADDR_W];
  assign exec_operand    = ir[ADDR_W-1:0];
  assign pc_sload        = (state == ST_DECODE) && br_sload;
  assign pc_load_data    = pc_sload ? br_load_data : '0;
  assign pc_count_enable = ((state == ST_DECODE) && br_count_enable) ||
                           ((state == ST_EXEC) && exec_ready);
  assign halted          = (state == ST_HALTED);

endmodule

// File: tb/tb_nano_sequencer.sv
// Scoreboard bench for nano_sequencer: an external PC counter and ROM model, expected PC strobes queued per program.
module tb_nano_sequencer;
  import nano_pkg::*;

  localparam int ADDR_W = 4;
  localparam int OP_W   = 4;
  localparam int IW     = 8;

  logic              clock = 1'b0;
  logic              areset = 1'b0;
  logic              run = 1'b0;
  logic [ADDR_W-1:0] pc_value;
  logic              pc_count_enable, pc_sload, mem_req, exec_valid, halted;
  logic [ADDR_W-1:0] pc_load_data, mem_addr, exec_operand;
  logic [OP_W-1:0]   exec_op;
  logic              mem_ack;
  logic [IW-1:0]     mem_rdata;
  logic              zero_flag = 1'b0;
  logic              exec_ready = 1'b0;
  logic              auto_ack = 1'b0;
  logic              man_ack = 1'b0;
  logic [IW-1:0]     rom [16];

  int checks = 0;
  int passed = 0;
  int cyc = 0;
  logic [5:0] exp_q [$];
  logic [5:0] obs_q [$];
  int         obs_cyc [$];

  nano_sequencer #(.ADDR_W(ADDR_W), .OP_W(OP_W)) dut (
    .clock(clock), .areset(areset), .run(run), .pc_value(pc_value),
    .pc_count_enable(pc_count_enable), .pc_sload(pc_sload), .pc_load_data(pc_load_data),
    .mem_addr(mem_addr), .mem_req(mem_req), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .zero_flag(zero_flag), .exec_valid(exec_valid), .exec_op(exec_op),
    .exec_operand(exec_operand), .exec_ready(exec_ready), .halted(halted)
  );

  always #5 clock = ~clock;

  assign mem_ack   = auto_ack | man_ack;
  assign mem_rdata = rom[mem_addr];

  // Program counter model, reset alongside the sequencer.
  always_ff @(posedge clock or negedge areset) begin
    if (!areset) pc_value <= '0;
    else if (pc_sload) pc_value <= pc_load_data;
    else if (pc_count_enable) pc_value <= pc_value + 4'd1;
  end

  always @(posedge clock) cyc <= cyc + 1;

  // Any strobe or nonzero load data is logged as {count_enable, sload, load_data}.
  always @(negedge clock) begin
    if (pc_count_enable || pc_sload || (pc_load_data != '0)) begin
      obs_q.push_back({pc_count_enable, pc_sload, pc_load_data});
      obs_cyc.push_back(cyc);
    end
  end

  task automatic do_reset();
    areset = 1'b0; run = 1'b0; auto_ack = 1'b0; man_ack = 1'b0;
    exec_ready = 1'b0; zero_flag = 1'b0;
    @(posedge clock); #1;
    exp_q.delete(); obs_q.delete(); obs_cyc.delete();
    for (int i = 0; i < 16; i++) rom[i] = 8'hF0;
  endtask

  task automatic release_reset();
    @(posedge clock); #1;
    areset = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    run = 1'b1; auto_ack = 1'b1; exec_ready = 1'b1; zero_flag = 1'b1;
    #1;
    checks++;
    if ({pc_count_enable, pc_sload, pc_load_data, mem_req, exec_valid, halted, exec_op, exec_operand} !== 17'h0)
      $display("FAIL reset_outputs: got %h want 0",
               {pc_count_enable, pc_sload, pc_load_data, mem_req, exec_valid, halted, exec_op, exec_operand});
    else passed++;
    checks++;
    if (mem_addr !== pc_value) $display("FAIL reset_mem_addr: got %h want %h", mem_addr, pc_value);
    else passed++;
  endtask

  task automatic test_nop_halt();
    int hcyc;
    int c0, c1;
    logic [5:0] e, o;
    do_reset();
    rom[0] = 8'h00; rom[1] = 8'h00; rom[2] = 8'hF0;
    exp_q.push_back(6'b10_0000);
    exp_q.push_back(6'b10_0000);
    run = 1'b1; auto_ack = 1'b1;
    release_reset();
    hcyc = -1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clock);
      if (halted && hcyc < 0) hcyc = cyc;
    end
    checks++;
    if (obs_q.size() != exp_q.size()) $display("FAIL nop_strobe_count: got %0d want %0d", obs_q.size(), exp_q.size());
    else passed++;
    c0 = (obs_cyc.size() > 0) ? obs_cyc[0] : -100;
    c1 = (obs_cyc.size() > 1) ? obs_cyc[1] : -100;
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      checks++;
      if (o !== e) $display("FAIL nop_strobe: got %b want %b", o, e);
      else passed++;
    end
    checks++;
    if (c1 - c0 != 2) $display("FAIL nop_spacing: got %0d want 2", c1 - c0);
    else passed++;
    checks++;
    if (hcyc - c1 != 3) $display("FAIL halt_latency: got %0d want 3", hcyc - c1);
    else passed++;
    checks++;
    if ({pc_value, halted, mem_req} !== {4'd2, 1'b1, 1'b0})
      $display("FAIL halt_state: got pc=%h halted=%b req=%b want pc=2 halted=1 req=0", pc_value, halted, mem_req);
    else passed++;
  endtask

  task automatic test_jmp();
    logic nxt;
    logic [5:0] e, o;
    do_reset();
    rom[0] = 8'h1A;
    exp_q.push_back(6'b01_1010);
    run = 1'b1; auto_ack = 1'b1;
    release_reset();
    nxt = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      if (nxt) begin
        checks++;
        if ({mem_req, mem_addr} !== {1'b1, 4'hA}) $display("FAIL jmp_next_addr: got %b/%h want 1/a", mem_req, mem_addr);
        else passed++;
        nxt = 1'b0;
      end
      if (pc_sload) nxt = 1'b1;
    end
    checks++;
    if (obs_q.size() != 1) $display("FAIL jmp_strobe_count: got %0d want 1", obs_q.size());
    else passed++;
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      checks++;
      if (o !== e) $display("FAIL jmp_strobe: got %b want %b", o, e);
      else passed++;
    end
  endtask

  task automatic test_jz();
    logic [5:0] e, o;
    do_reset();
    rom[0] = 8'h25; rom[5] = 8'h25; rom[6] = 8'hF0;
    exp_q.push_back(6'b01_0101);
    exp_q.push_back(6'b10_0000);
    run = 1'b1; auto_ack = 1'b1; zero_flag = 1'b1;
    release_reset();
    for (int i = 0; i < 12; i++) begin
      @(posedge clock); #1;
      zero_flag = (pc_value == 4'd0);
    end
    checks++;
    if (obs_q.size() != exp_q.size()) $display("FAIL jz_strobe_count: got %0d want %0d", obs_q.size(), exp_q.size());
    else passed++;
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      checks++;
      if (o !== e) $display("FAIL jz_strobe: got %b want %b", o, e);
      else passed++;
    end
    checks++;
    if (pc_value !== 4'd6) $display("FAIL jz_final_pc: got %h want 6", pc_value);
    else passed++;
  endtask

  task automatic test_alu_stall();
    int nv, rdy_cyc;
    logic [5:0] e, o;
    do_reset();
    rom[0] = 8'h43; rom[1] = 8'hF0;
    exp_q.push_back(6'b10_0000);
    run = 1'b1; auto_ack = 1'b1;
    release_reset();
    nv = 0; rdy_cyc = -1;
    for (int i = 0; i < 14; i++) begin
      @(posedge clock); #1;
      exec_ready = 1'b0;
      if (exec_valid) begin
        nv++;
        checks++;
        if ({exec_op, exec_operand} !== 8'h43) $display("FAIL alu_fields: got %h want 43", {exec_op, exec_operand});
        else passed++;
        if (nv == 4) begin
          exec_ready = 1'b1;
          rdy_cyc = cyc;
        end
      end
    end
    checks++;
    if (nv != 4) $display("FAIL alu_valid_cycles: got %0d want 4", nv);
    else passed++;
    checks++;
    if (obs_q.size() != 1 || obs_cyc[0] != rdy_cyc)
      $display("FAIL alu_ce_timing: got n=%0d cyc=%0d want n=1 cyc=%0d", obs_q.size(),
               (obs_cyc.size() > 0) ? obs_cyc[0] : -1, rdy_cyc);
    else passed++;
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      checks++;
      if (o !== e) $display("FAIL alu_strobe: got %b want %b", o, e);
      else passed++;
    end
  endtask

  task automatic test_mem_wait();
    logic [1:0] pat [6];
    logic [5:0] e, o;
    pat[0] = 2'b10; pat[1] = 2'b01; pat[2] = 2'b00;
    pat[3] = 2'b10; pat[4] = 2'b10; pat[5] = 2'b11;
    do_reset();
    rom[0] = 8'h43; rom[1] = 8'hF0;
    exec_ready = 1'b1;
    exp_q.push_back(6'b10_0000);
    release_reset();
    for (int k = 0; k < 6; k++) begin
      @(posedge clock); #1;
      run = pat[k][1]; man_ack = pat[k][0];
      #1;
      checks++;
      if ({mem_req, exec_op, exec_operand} !== {run, 8'h00})
        $display("FAIL wait_k%0d: got req=%b ir=%h want req=%b ir=00", k, mem_req, {exec_op, exec_operand}, run);
      else passed++;
    end
    checks++;
    if (obs_q.size() != 0) $display("FAIL wait_no_strobe: got %0d want 0", obs_q.size());
    else passed++;
    @(posedge clock); #1;
    man_ack = 1'b0;
    checks++;
    if ({exec_op, exec_operand} !== 8'h43) $display("FAIL wait_ir_load: got %h want 43", {exec_op, exec_operand});
    else passed++;
    repeat (6) @(posedge clock);
    @(negedge clock);
    checks++;
    if (obs_q.size() != exp_q.size()) $display("FAIL wait_strobe_count: got %0d want %0d", obs_q.size(), exp_q.size());
    else passed++;
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      checks++;
      if (o !== e) $display("FAIL wait_strobe: got %b want %b", o, e);
      else passed++;
    end
  endtask

  task automatic test_reset_exec();
    do_reset();
    rom[0] = 8'h47;
    run = 1'b1; auto_ack = 1'b1;
    release_reset();
    for (int i = 0; i < 10 && !exec_valid; i++) begin
      @(posedge clock); #1;
    end
    checks++;
    if (exec_valid !== 1'b1) $display("FAIL rexec_enter: timeout got %b want 1", exec_valid);
    else passed++;
    #2;
    areset = 1'b0;
    exec_ready = 1'b1;
    #1;
    checks++;
    if ({exec_valid, pc_count_enable, pc_sload, mem_req, halted, exec_op, exec_operand} !== 13'h0)
      $display("FAIL rexec_abort: got %h want 0",
               {exec_valid, pc_count_enable, pc_sload, mem_req, halted, exec_op, exec_operand});
    else passed++;
    @(posedge clock); #1;
    auto_ack = 1'b0; exec_ready = 1'b0;
    areset = 1'b1;
    #1;
    checks++;
    if ({mem_req, exec_valid, obs_q.size() == 0} !== 3'b101)
      $display("FAIL rexec_fetch: got req=%b valid=%b strobes=%0d want 1/0/0", mem_req, exec_valid, obs_q.size());
    else passed++;
  endtask

  task automatic test_op3();
    logic saw_exec, want_exec;
    logic [5:0] e, o;
    do_reset();
    rom[0] = 8'h39;
`ifdef NANO_SEQ_JNZ_EN
    exp_q.push_back(6'b01_1001);
    want_exec = 1'b0;
`else
    exp_q.push_back(6'b10_0000);
    want_exec = 1'b1;
`endif
    run = 1'b1; auto_ack = 1'b1; exec_ready = 1'b1; zero_flag = 1'b0;
    release_reset();
    saw_exec = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      if (exec_valid && exec_op == 4'd3) saw_exec = 1'b1;
    end
    checks++;
    if (saw_exec !== want_exec) $display("FAIL op3_exec: got %b want %b", saw_exec, want_exec);
    else passed++;
    checks++;
    if (obs_q.size() != exp_q.size()) $display("FAIL op3_strobe_count: got %0d want %0d", obs_q.size(), exp_q.size());
    else passed++;
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      checks++;
      if (o !== e) $display("FAIL op3_strobe: got %b want %b", o, e);
      else passed++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_nop_halt();
    test_jmp();
    test_jz();
    test_alu_stall();
    test_mem_wait();
    test_reset_exec();
    test_op3();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
